// File: rtl/ysyx_22040750_axi_pkg.sv
// Shared constants for the AXI crossbars: state encoding, channel ids and response codes.
package ysyx_22040750_axi_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StAddr = ADDR,
    StData = DATA,
    StResp = RESP
  } state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_22040750_rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// The pointer moves to the loser only when i_update is pulsed with the winner id.
module ysyx_22040750_rr_arb2
  import ysyx_22040750_axi_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_winner,
  output logic       o_grant,
  output logic       o_any
);

  logic r_prio;

  // Priority pointer: after a served request the other channel is preferred.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio <= CH0;
    end else if (i_update) begin
      r_prio <= ~i_winner;
    end
  end

  // Grant: a lone requester wins, a tie goes to the priority holder.
  always_comb begin
    o_any = |i_req;
    case (i_req)
      2'b01:   o_grant = CH0;
      2'b10:   o_grant = CH1;
      2'b11:   o_grant = r_prio;
      default: o_grant = CH0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040750_axi_wr_crossbar.sv
// Two-initiator AXI4 write crossbar (ch0 = dcache writeback, ch1 = uncached store path).
// One burst at a time; the owner keeps AW, W and B until its B handshake.
// Optional macro YSYX_22040750_WLAST_CHECK_EN: wlast is generated from the captured awlen and a
// mismatching initiator wlast raises the sticky O_wlast_err flag.
module ysyx_22040750_axi_wr_crossbar
  import ysyx_22040750_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                I_clk,
  input  logic                I_rst,
  output logic [ADDR_W-1:0]   O_axi_awaddr,
  output logic                O_axi_awvalid,
  input  logic                I_axi_awready,
  output logic [7:0]          O_axi_awlen,
  output logic [2:0]          O_axi_awsize,
  output logic [DATA_W-1:0]   O_axi_wdata,
  output logic [DATA_W/8-1:0] O_axi_wstrb,
  output logic                O_axi_wvalid,
  output logic                O_axi_wlast,
  input  logic                I_axi_wready,
  input  logic                I_axi_bvalid,
  input  logic [1:0]          I_axi_bresp,
  output logic                O_axi_bready,
  input  logic [ADDR_W-1:0]   I_ch0_awaddr,
  input  logic                I_ch0_awvalid,
  input  logic [7:0]          I_ch0_awlen,
  input  logic [2:0]          I_ch0_awsize,
  output logic                O_ch0_awready,
  input  logic [DATA_W-1:0]   I_ch0_wdata,
  input  logic [DATA_W/8-1:0] I_ch0_wstrb,
  input  logic                I_ch0_wvalid,
  input  logic                I_ch0_wlast,
  output logic                O_ch0_wready,
  output logic                O_ch0_bvalid,
  output logic [1:0]          O_ch0_bresp,
  input  logic                I_ch0_bready,
  input  logic [ADDR_W-1:0]   I_ch1_awaddr,
  input  logic                I_ch1_awvalid,
  input  logic [7:0]          I_ch1_awlen,
  input  logic [2:0]          I_ch1_awsize,
  output logic                O_ch1_awready,
  input  logic [DATA_W-1:0]   I_ch1_wdata,
  input  logic [DATA_W/8-1:0] I_ch1_wstrb,
  input  logic                I_ch1_wvalid,
  input  logic                I_ch1_wlast,
  output logic                O_ch1_wready,
  output logic                O_ch1_bvalid,
  output logic [1:0]          O_ch1_bresp,
  input  logic                I_ch1_bready,
  output logic                O_wlast_err
);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_owner;

  logic                w_grant;
  logic                w_any;
  logic [ADDR_W-1:0]   w_awaddr;
  logic                w_awvalid;
  logic [7:0]          w_awlen;
  logic [2:0]          w_awsize;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W/8-1:0] w_wstrb;
  logic                w_wvalid;
  logic                w_wlast_in;
  logic                w_wlast_out;
  logic                w_bready;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_b_hs;

  // Owner-selected view of both initiators.
  assign w_awaddr   = r_owner ? I_ch1_awaddr  : I_ch0_awaddr;
  assign w_awvalid  = r_owner ? I_ch1_awvalid : I_ch0_awvalid;
  assign w_awlen    = r_owner ? I_ch1_awlen   : I_ch0_awlen;
  assign w_awsize   = r_owner ? I_ch1_awsize  : I_ch0_awsize;
  assign w_wdata    = r_owner ? I_ch1_wdata   : I_ch0_wdata;
  assign w_wstrb    = r_owner ? I_ch1_wstrb   : I_ch0_wstrb;
  assign w_wvalid   = r_owner ? I_ch1_wvalid  : I_ch0_wvalid;
  assign w_wlast_in = r_owner ? I_ch1_wlast   : I_ch0_wlast;
  assign w_bready   = r_owner ? I_ch1_bready  : I_ch0_bready;

  assign w_aw_hs = (r_state == StAddr) && w_awvalid && I_axi_awready;
  assign w_w_hs  = (r_state == StData) && w_wvalid && I_axi_wready;
  assign w_b_hs  = (r_state == StResp) && I_axi_bvalid && w_bready;

  ysyx_22040750_rr_arb2 u_arb (
    .i_clk    (I_clk),
    .i_rst    (I_rst),
    .i_req    ({I_ch1_awvalid, I_ch0_awvalid}),
    .i_update (w_aw_hs),
    .i_winner (r_owner),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );

`ifdef YSYX_22040750_WLAST_CHECK_EN
  logic [7:0] r_cnt;
  logic [7:0] r_len;
  logic       r_err;

  assign w_wlast_out = (r_cnt == r_len);
  assign O_wlast_err = r_err;

  // Beat counter against the captured awlen; a disagreeing initiator wlast is latched as error.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_cnt <= 8'd0;
      r_len <= 8'd0;
      r_err <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_len <= w_awlen;
        r_cnt <= 8'd0;
      end
      if (w_w_hs) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_wlast_in != w_wlast_out) r_err <= 1'b1;
      end
    end
  end
`else
  assign w_wlast_out = w_wlast_in;
  assign O_wlast_err = 1'b0;
`endif

  // State and ownership registers; owner is latched only when leaving IDLE.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state <= StIdle;
      r_owner <= CH0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == StIdle) && w_any) r_owner <= w_grant;
    end
  end

  // Next state and channel forwarding; everything outside its own phase stays 0.
  always_comb begin
    w_state_nxt   = r_state;
    O_axi_awaddr  = '0;
    O_axi_awvalid = 1'b0;
    O_axi_awlen   = 8'd0;
    O_axi_awsize  = 3'd0;
    O_axi_wdata   = '0;
    O_axi_wstrb   = '0;
    O_axi_wvalid  = 1'b0;
    O_axi_wlast   = 1'b0;
    O_axi_bready  = 1'b0;
    O_ch0_awready = 1'b0;
    O_ch1_awready = 1'b0;
    O_ch0_wready  = 1'b0;
    O_ch1_wready  = 1'b0;
    O_ch0_bvalid  = 1'b0;
    O_ch1_bvalid  = 1'b0;
    O_ch0_bresp   = OKAY;
    O_ch1_bresp   = OKAY;
    case (r_state)
      StIdle: begin
        if (w_any) w_state_nxt = StAddr;
      end
      StAddr: begin
        O_axi_awaddr  = w_awaddr;
        O_axi_awvalid = w_awvalid;
        O_axi_awlen   = w_awlen;
        O_axi_awsize  = w_awsize;
        if (r_owner) O_ch1_awready = I_axi_awready;
        else         O_ch0_awready = I_axi_awready;
        if (w_aw_hs) w_state_nxt = StData;
      end
      StData: begin
        O_axi_wdata  = w_wdata;
        O_axi_wstrb  = w_wstrb;
        O_axi_wvalid = w_wvalid;
        O_axi_wlast  = w_wlast_out;
        if (r_owner) O_ch1_wready = I_axi_wready;
        else         O_ch0_wready = I_axi_wready;
        if (w_w_hs && w_wlast_out) w_state_nxt = StResp;
      end
      StResp: begin
        O_axi_bready = w_bready;
        if (r_owner) begin
          O_ch1_bvalid = I_axi_bvalid;
          O_ch1_bresp  = I_axi_bresp;
        end else begin
          O_ch0_bvalid = I_axi_bvalid;
          O_ch0_bresp  = I_axi_bresp;
        end
        if (w_b_hs) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040750_axi_wr_crossbar.sv
// Directed testbench for the two-initiator AXI write crossbar.
module tb_ysyx_22040750_axi_wr_crossbar;

  logic        clk;
  logic        rst;
  logic [31:0] axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wlast;
  logic        axi_wready;
  logic        axi_bvalid;
  logic [1:0]  axi_bresp;
  logic        axi_bready;
  logic        wlast_err;

  logic [31:0] awaddr  [2];
  logic        awvalid [2];
  logic [7:0]  awlen   [2];
  logic [2:0]  awsize  [2];
  logic        awready [2];
  logic [63:0] wdata   [2];
  logic [7:0]  wstrb   [2];
  logic        wvalid  [2];
  logic        wlast   [2];
  logic        wready  [2];
  logic        bvalid  [2];
  logic [1:0]  bresp   [2];
  logic        bready  [2];

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22040750_axi_wr_crossbar #(.ADDR_W(32), .DATA_W(64)) dut (
    .I_clk         (clk),
    .I_rst         (rst),
    .O_axi_awaddr  (axi_awaddr),
    .O_axi_awvalid (axi_awvalid),
    .I_axi_awready (axi_awready),
    .O_axi_awlen   (axi_awlen),
    .O_axi_awsize  (axi_awsize),
    .O_axi_wdata   (axi_wdata),
    .O_axi_wstrb   (axi_wstrb),
    .O_axi_wvalid  (axi_wvalid),
    .O_axi_wlast   (axi_wlast),
    .I_axi_wready  (axi_wready),
    .I_axi_bvalid  (axi_bvalid),
    .I_axi_bresp   (axi_bresp),
    .O_axi_bready  (axi_bready),
    .I_ch0_awaddr  (awaddr[0]),
    .I_ch0_awvalid (awvalid[0]),
    .I_ch0_awlen   (awlen[0]),
    .I_ch0_awsize  (awsize[0]),
    .O_ch0_awready (awready[0]),
    .I_ch0_wdata   (wdata[0]),
    .I_ch0_wstrb   (wstrb[0]),
    .I_ch0_wvalid  (wvalid[0]),
    .I_ch0_wlast   (wlast[0]),
    .O_ch0_wready  (wready[0]),
    .O_ch0_bvalid  (bvalid[0]),
    .O_ch0_bresp   (bresp[0]),
    .I_ch0_bready  (bready[0]),
    .I_ch1_awaddr  (awaddr[1]),
    .I_ch1_awvalid (awvalid[1]),
    .I_ch1_awlen   (awlen[1]),
    .I_ch1_awsize  (awsize[1]),
    .O_ch1_awready (awready[1]),
    .I_ch1_wdata   (wdata[1]),
    .I_ch1_wstrb   (wstrb[1]),
    .I_ch1_wvalid  (wvalid[1]),
    .I_ch1_wlast   (wlast[1]),
    .O_ch1_wready  (wready[1]),
    .O_ch1_bvalid  (bvalid[1]),
    .O_ch1_bresp   (bresp[1]),
    .I_ch1_bready  (bready[1]),
    .O_wlast_err   (wlast_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awvalid"}, 64'(axi_awvalid), 64'd0);
    check({tag, "_awaddr"},  64'(axi_awaddr),  64'd0);
    check({tag, "_awlen"},   64'(axi_awlen),   64'd0);
    check({tag, "_wvalid"},  64'(axi_wvalid),  64'd0);
    check({tag, "_wdata"},   axi_wdata,        64'd0);
    check({tag, "_wstrb"},   64'(axi_wstrb),   64'd0);
    check({tag, "_wlast"},   64'(axi_wlast),   64'd0);
    check({tag, "_bready"},  64'(axi_bready),  64'd0);
    check({tag, "_readys"},  64'({awready[0], awready[1], wready[0], wready[1]}), 64'd0);
    check({tag, "_bvalids"}, 64'({bvalid[0], bvalid[1], bresp[0], bresp[1]}), 64'd0);
    check({tag, "_err"},     64'(wlast_err),   64'd0);
  endtask

  task automatic req(input int ch, input logic [31:0] addr, input logic [7:0] len);
    awvalid[ch] = 1'b1;
    awaddr[ch]  = addr;
    awlen[ch]   = len;
    awsize[ch]  = 3'd3;
  endtask

  // Entered in IDLE with the request(s) already raised.
  task automatic aw_phase(input int ch, input logic [31:0] addr, input logic [7:0] len);
    #1;
    check("aw_bubble", 64'(axi_awvalid), 64'd0);
    tick();
    #1;
    check("aw_valid", 64'(axi_awvalid), 64'd1);
    check("aw_addr", 64'(axi_awaddr), 64'(addr));
    check("aw_len", 64'(axi_awlen), 64'(len));
    check("aw_size", 64'(axi_awsize), 64'd3);
    check("aw_ready_own", 64'(awready[ch]), 64'd1);
    check("aw_ready_other", 64'(awready[1-ch]), 64'd0);
    check("aw_w_held", 64'({axi_wvalid, wready[ch]}), 64'd0);
    tick();
    awvalid[ch] = 1'b0;
    #1;
    check("aw_dropped", 64'(axi_awvalid), 64'd0);
  endtask

  // mlast is the beat index on which the initiator raises its own wlast.
  task automatic w_phase(input int ch, input logic [7:0] len, input bit toggle, input int mlast,
                         input logic [63:0] base);
    int   beats = 0;
    bit   ph    = 1'b1;
    bit   done  = 1'b0;
    logic exp_last;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      wvalid[ch] = 1'b1;
      wdata[ch]  = base + 64'(beats);
      wstrb[ch]  = 8'hff;
      wlast[ch]  = (beats == mlast);
      axi_wready = toggle ? ph : 1'b1;
      #1;
`ifdef YSYX_22040750_WLAST_CHECK_EN
      exp_last = (beats == int'(len));
`else
      exp_last = (beats == mlast);
`endif
      check("w_valid", 64'(axi_wvalid), 64'd1);
      check("w_data", axi_wdata, base + 64'(beats));
      check("w_strb", 64'(axi_wstrb), 64'hff);
      check("w_last", 64'(axi_wlast), 64'(exp_last));
      check("w_ready_own", 64'(wready[ch]), 64'(axi_wready));
      check("w_ready_other", 64'(wready[1-ch]), 64'd0);
      tick();
      if (axi_wready) begin
        if (exp_last) done = 1'b1;
        beats++;
      end
      ph = ~ph;
    end
    wvalid[ch] = 1'b0;
    wlast[ch]  = 1'b0;
    axi_wready = 1'b1;
    check("w_done", 64'(done), 64'd1);
    check("w_beats", 64'(beats), 64'(int'(len) + 1));
  endtask

  task automatic b_phase(input int ch, input logic [1:0] resp, input int delay);
    axi_bvalid = 1'b1;
    axi_bresp  = resp;
    bready[ch] = 1'b0;
    for (int d = 0; d < delay; d++) begin
      #1;
      check("b_bready_low", 64'(axi_bready), 64'd0);
      check("b_valid_own", 64'(bvalid[ch]), 64'd1);
      check("b_resp_own", 64'(bresp[ch]), 64'(resp));
      check("b_other", 64'({bvalid[1-ch], bresp[1-ch]}), 64'd0);
      tick();
    end
    bready[ch] = 1'b1;
    #1;
    check("b_bready", 64'(axi_bready), 64'd1);
    check("b_valid_own", 64'(bvalid[ch]), 64'd1);
    check("b_resp_own", 64'(bresp[ch]), 64'(resp));
    check("b_other", 64'({bvalid[1-ch], bresp[1-ch]}), 64'd0);
    tick();
    axi_bvalid = 1'b0;
    axi_bresp  = 2'b00;
    bready[ch] = 1'b0;
    #1;
    check("b_done", 64'({bvalid[ch], axi_bready}), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    axi_awready = 1'b1;
    axi_wready  = 1'b1;
    axi_bvalid  = 1'b0;
    axi_bresp   = 2'b00;
    for (int c = 0; c < 2; c++) begin
      awaddr[c] = '0; awvalid[c] = 1'b0; awlen[c] = '0; awsize[c] = '0;
      wdata[c]  = '0; wstrb[c]   = '0;   wvalid[c] = 1'b0; wlast[c] = 1'b0;
      bready[c] = 1'b0;
    end
    do_reset();
    #1;
    check_all_zero("reset");

    // Single ch0 burst, 4 beats.
    tick();
    req(0, 32'h8000_0000, 8'd3);
    aw_phase(0, 32'h8000_0000, 8'd3);
    w_phase(0, 8'd3, 1'b0, 3, 64'h1111_0000_0000_0000);
    b_phase(0, 2'b00, 0);

    // Arbitration after reset: ch0, ch1, then ch0 again on a tie.
    do_reset();
    req(0, 32'h8000_1000, 8'd0);
    req(1, 32'h1000_0000, 8'd0);
    aw_phase(0, 32'h8000_1000, 8'd0);
    w_phase(0, 8'd0, 1'b0, 0, 64'hA0);
    b_phase(0, 2'b00, 0);
    aw_phase(1, 32'h1000_0000, 8'd0);
    w_phase(1, 8'd0, 1'b0, 0, 64'hB0);
    b_phase(1, 2'b00, 0);
    req(0, 32'h8000_2000, 8'd0);
    req(1, 32'h1000_0040, 8'd1);
    aw_phase(0, 32'h8000_2000, 8'd0);
    w_phase(0, 8'd0, 1'b0, 0, 64'hC0);
    b_phase(0, 2'b00, 0);

    // Pending ch1: 2-beat burst with toggling wready, SLVERR, bready held low 3 cycles.
    aw_phase(1, 32'h1000_0040, 8'd1);
    w_phase(1, 8'd1, 1'b1, 1, 64'hD0);
    b_phase(1, 2'b10, 3);

    // Early W on ch0: held off until DATA.
    wvalid[0] = 1'b1;
    wdata[0]  = 64'hE0;
    wstrb[0]  = 8'hff;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("early_w_fwd", 64'({axi_wvalid, wready[0]}), 64'd0);
      tick();
    end
    req(0, 32'h8000_3000, 8'd1);
    aw_phase(0, 32'h8000_3000, 8'd1);
    w_phase(0, 8'd1, 1'b0, 1, 64'hE0);
    b_phase(0, 2'b00, 0);

`ifdef YSYX_22040750_WLAST_CHECK_EN
    // Initiator claims wlast on beat 1 of a 3-beat burst.
    check("err_before", 64'(wlast_err), 64'd0);
    req(0, 32'h8000_4000, 8'd2);
    aw_phase(0, 32'h8000_4000, 8'd2);
    w_phase(0, 8'd2, 1'b0, 1, 64'hF0);
    check("err_set", 64'(wlast_err), 64'd1);
    b_phase(0, 2'b00, 0);
    tick();
    tick();
    check("err_held", 64'(wlast_err), 64'd1);
`endif

    // Reset in the middle of a ch0 data phase.
    req(0, 32'h8000_5000, 8'd3);
    aw_phase(0, 32'h8000_5000, 8'd3);
    wvalid[0] = 1'b1;
    wdata[0]  = 64'h55;
    wstrb[0]  = 8'hff;
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("mid_rst");
    rst       = 1'b0;
    wvalid[0] = 1'b0;
    req(1, 32'h1000_0080, 8'd0);
    aw_phase(1, 32'h1000_0080, 8'd0);
    w_phase(1, 8'd0, 1'b0, 0, 64'h66);
    b_phase(1, 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
